// File: rtl/draw_pkg.sv
// Shared definitions for the board-drawing controller: screen codes,
// FSM state type, field widths and cell-code sanitisation.
package draw_pkg;

    localparam int unsigned X_W        = 3;
    localparam int unsigned Y_W        = 3;
    localparam int unsigned CELL_IDX_W = X_W + Y_W;
    localparam int unsigned CODE_W     = 6;
    localparam int unsigned CNT_W      = 15;

    localparam logic [4:0] DRAW_BOARD = 5'b11000;
    localparam logic [4:0] DRAW_TURN  = 5'b11100;
    localparam logic [4:0] DRAW_EMPTY = 5'b00000;
    localparam logic [4:0] DRAW_WALL  = 5'b11111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_BG,
        ST_BGEND,
        ST_FETCH,
        ST_CELL,
        ST_NEXT,
        ST_TURN,
        ST_FIN
    } draw_state_t;

    // Board and turn codes are screen-only; a board cell holding one draws as empty.
    function automatic logic [CODE_W-1:0] sanitize_code(input logic [CODE_W-1:0] code);
        if (code[4:0] == DRAW_BOARD || code[4:0] == DRAW_TURN)
            return {1'b0, DRAW_EMPTY};
        return code;
    endfunction

endpackage

// File: rtl/draw_step_counter.sv
// Loadable 15-bit step counter with terminal-count compare; times the
// BG, FETCH, CELL and TURN phases of a refresh.
module draw_step_counter
    import draw_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Load on request, otherwise count up every cycle.
    always_ff @(posedge clk) begin
        if (!resetn)
            count <= '0;
        else if (load)
            count <= load_val;
        else
            count <= count + 1'b1;
    end

    assign tc = (count == term);

endmodule

// File: rtl/draw_board_control.sv
// Sequences one screen refresh: background fill, 64 board cells in raster
// order fetched from board memory, then the turn-indicator square.
module draw_board_control
    import draw_pkg::*;
#(
    parameter int unsigned BG_PIXELS   = 32768,
    parameter int unsigned CELL_PIXELS = 256,
    parameter int unsigned NUM_CELLS   = 64,
    parameter int unsigned MEM_LAT     = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    output logic [5:0] mem_addr,
    input  logic [5:0] mem_rdata,
    output logic [5:0] draw_value,
    output logic       write,
    output logic       update_x_y,
    output logic       ctr_clr,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    draw_state_t           state;
    draw_state_t           state_next;
    logic [CELL_IDX_W-1:0] cell_idx;
    logic [CODE_W-1:0]     cell_q;
    logic                  pending;
    logic [CNT_W-1:0]      step_term;
    logic                  step_load;
    logic                  step_tc;
    logic                  last_cell;

    assign last_cell = (cell_idx == CELL_IDX_W'(NUM_CELLS - 1));
    // Pixel counter restarts from zero on every state entry.
    assign step_load = (state_next != state);

    draw_step_counter u_step (
        .clk      (clk),
        .resetn   (resetn),
        .load     (step_load),
        .load_val ('0),
        .term     (step_term),
        .tc       (step_tc)
    );

    // Terminal count for the phase currently being timed.
    always_comb begin
        step_term = '0;
        case (state)
            ST_BG:           step_term = CNT_W'(BG_PIXELS - 1);
            ST_FETCH:        step_term = CNT_W'(MEM_LAT - 1);
            ST_CELL,
            ST_TURN:         step_term = CNT_W'(CELL_PIXELS - 1);
            default:         step_term = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_BG;
            ST_BG:    if (step_tc) state_next = ST_BGEND;
            ST_BGEND: state_next = ST_FETCH;
            ST_FETCH: if (step_tc) state_next = ST_CELL;
            ST_CELL:  if (step_tc) state_next = ST_NEXT;
            ST_NEXT:  state_next = last_cell ? ST_TURN : ST_FETCH;
            ST_TURN:  if (step_tc) state_next = ST_FIN;
            // A start arriving in FIN itself is taken directly rather than left queued.
            ST_FIN:   state_next = (pending || start) ? ST_CLEAR : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Cell index, fetched cell code and the single queued-refresh flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cell_idx <= '0;
            cell_q   <= '0;
            pending  <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: cell_idx <= '0;
                ST_FETCH: if (step_tc) cell_q <= sanitize_code(mem_rdata);
                ST_NEXT:  cell_idx <= last_cell ? '0 : cell_idx + 1'b1;
                default:  ;
            endcase
            if (state == ST_FIN)
                pending <= 1'b0;
            else if (state != ST_IDLE && start)
                pending <= 1'b1;
        end
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            write      <= 1'b0;
            update_x_y <= 1'b0;
            ctr_clr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_plot   <= 1'b0;
        end else begin
            write      <= (state_next == ST_BG) || (state_next == ST_CELL) ||
                          (state_next == ST_TURN);
            update_x_y <= (state_next == ST_NEXT);
            ctr_clr    <= (state_next == ST_CLEAR) || (state_next == ST_BGEND);
            busy       <= (state_next != ST_IDLE);
            done       <= (state_next == ST_FIN);
            vga_plot   <= write;
        end
    end

    // Colour code and memory address decoded from the current state.
    always_comb begin
        draw_value = '0;
        mem_addr   = '0;
        case (state)
            ST_BG:    draw_value = {1'b0, DRAW_BOARD};
            ST_FETCH: mem_addr   = cell_idx;
            ST_CELL: begin
                mem_addr   = cell_idx;
                draw_value = cell_q;
            end
            ST_TURN:  draw_value = {1'b0, DRAW_TURN};
            default: begin
                draw_value = '0;
                mem_addr   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_draw_board_control.sv
// Self-checking bench for draw_board_control: a scaled instance checked
// cycle by cycle against a schedule model, plus a full-size MEM_LAT=3 instance.
module tb_draw_board_control;

    localparam int BG   = 1024;
    localparam int CP   = 32;
    localparam int NC   = 64;
    localparam int PER  = CP + 2;
    localparam int CS   = BG + 2;
    localparam int TS   = CS + NC * PER;
    localparam int LEN  = TS + CP + 1;
    localparam int WR   = BG + NC * CP + CP;
    localparam int LEN3 = 1 + 32768 + 1 + 64 * (3 + 256 + 1) + 256 + 1;
    localparam int WR3  = 32768 + 64 * 256 + 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, start, start3;
    logic [5:0] addr1, rdata1, dv1, addr3, rdata3, dv3;
    logic       wr1, upd1, clr1, vga1, busy1, done1;
    logic       wr3, upd3, clr3, vga3, busy3, done3;
    logic [5:0] mem1 [64];
    logic [5:0] mem3 [64];
    int         age3 = 0;

    assign rdata1 = mem1[addr1];
    // Slow memory: junk until the address has been up for three FETCH cycles.
    assign rdata3 = (age3 >= 2) ? mem3[addr3] : 6'b101010;
    always @(posedge clk) age3 <= (wr3 | upd3 | clr3) ? 0 : age3 + 1;

    draw_board_control #(.BG_PIXELS(BG), .CELL_PIXELS(CP), .NUM_CELLS(NC), .MEM_LAT(1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .mem_addr(addr1), .mem_rdata(rdata1),
        .draw_value(dv1), .write(wr1), .update_x_y(upd1), .ctr_clr(clr1),
        .vga_plot(vga1), .busy(busy1), .done(done1));

    draw_board_control #(.MEM_LAT(3)) dut3 (
        .clk(clk), .resetn(resetn), .start(start3), .mem_addr(addr3), .mem_rdata(rdata3),
        .draw_value(dv3), .write(wr3), .update_x_y(upd3), .ctr_clr(clr3),
        .vga_plot(vga3), .busy(busy3), .done(done3));

    typedef struct packed {
        logic       busy, write, upd, clr, done, vga;
        logic [5:0] dv, addr;
    } obs_t;

    typedef struct {
        int         idx;
        logic [5:0] code;
        logic [5:0] want;
    } cell_vec_t;

    cell_vec_t  vecs [10];
    logic [5:0] cell_dv  [64];
    int         cell_wr  [64];
    int         cell_chg [64];
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [5:0] expect_code(input logic [5:0] c);
        return (c[4:0] == 5'b11000 || c[4:0] == 5'b11100) ? 6'b000000 : c;
    endfunction

    // Expected outputs t cycles after a refresh starts, from the refresh schedule.
    function automatic obs_t model(input int t);
        obs_t o;
        int k, off;
        o = '0;
        o.busy = 1'b1;
        if (t == 0) o.clr = 1'b1;
        else if (t <= BG) begin o.write = 1'b1; o.dv = 6'b011000; end
        else if (t == BG + 1) o.clr = 1'b1;
        else if (t < TS) begin
            k = (t - CS) / PER;
            off = (t - CS) % PER;
            if (off == 0) o.addr = 6'(k);
            else if (off <= CP) begin
                o.write = 1'b1;
                o.addr = 6'(k);
                o.dv = expect_code(mem1[k]);
            end else o.upd = 1'b1;
        end
        else if (t < TS + CP) begin o.write = 1'b1; o.dv = 6'b011100; end
        else o.done = 1'b1;
        return o;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 7))
                0:       mem1[i] = {1'($urandom), 5'b11000};
                1:       mem1[i] = {1'($urandom), 5'b11100};
                default: mem1[i] = 6'($urandom);
            endcase
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Follow dut while busy, comparing every cycle to the model; drives start
    // high over [s_from, s_to] and resetn low at rst_at (cycle offsets).
    task automatic watch(input int s_from, input int s_to, input int rst_at,
                         output int busy_n, output int wr_n, output int upd_n,
                         output int clr_n, output int done_n, output int bad);
        int   t, tm, k;
        obs_t e, a;
        logic pw;
        t = 0; bad = 0; pw = 1'b0;
        wr_n = 0; upd_n = 0; clr_n = 0; done_n = 0;
        for (int i = 0; i < 64; i++) begin
            cell_wr[i] = 0; cell_chg[i] = 0; cell_dv[i] = '0;
        end
        while (busy1 === 1'b1 && t < 3 * LEN) begin
            tm = t % LEN;
            e = model(tm);
            e.vga = pw;
            pw = e.write;
            a = '0;
            a.busy = busy1; a.write = wr1; a.upd = upd1; a.clr = clr1;
            a.done = done1; a.vga = vga1; a.dv = dv1; a.addr = addr1;
            if (a !== e) begin
                if (bad == 0) $display("trace diff at t=%0d: dut %h model %h", t, a, e);
                bad++;
            end
            wr_n += int'(wr1); upd_n += int'(upd1); clr_n += int'(clr1); done_n += int'(done1);
            if (wr1 && tm >= CS && tm < TS) begin
                k = int'(addr1);
                if (cell_wr[k] > 0 && dv1 !== cell_dv[k]) cell_chg[k]++;
                cell_dv[k] = dv1;
                cell_wr[k]++;
            end
            start = (t >= s_from && t <= s_to);
            resetn = (t != rst_at);
            t++;
            @(negedge clk);
        end
        start = 1'b0;
        resetn = 1'b1;
        busy_n = t;
        check("watch_bound", longint'(t < 3 * LEN), 1);
    endtask

    initial begin
        int bn, wn, un, cn, dn, bad, rst_t, n, w3, d3, c5, c5b, c7, c7b;
        resetn = 1'b0; start = 1'b0; start3 = 1'b0;
        vecs[0] = '{0,  6'b011000, 6'b000000};
        vecs[1] = '{1,  6'b011100, 6'b000000};
        vecs[2] = '{9,  6'b100100, 6'b100100};
        vecs[3] = '{10, 6'b111000, 6'b000000};
        vecs[4] = '{11, 6'b111100, 6'b000000};
        vecs[5] = '{12, 6'b111111, 6'b111111};
        vecs[6] = '{13, 6'b011111, 6'b011111};
        vecs[7] = '{20, 6'b000001, 6'b000001};
        vecs[8] = '{62, 6'b011001, 6'b011001};
        vecs[9] = '{63, 6'b101010, 6'b101010};
        for (int i = 0; i < 64; i++) begin mem1[i] = '0; mem3[i] = '0; end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_write", wr1, 0);
        check("rst_done", done1, 0);
        check("rst_ctr_clr", clr1, 0);
        check("rst_update", upd1, 0);
        check("rst_vga", vga1, 0);
        check("rst_draw_value", dv1, 0);
        check("rst_mem_addr", addr1, 0);
        check("rst_busy3", busy3, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", busy1, 0);

        // Single refresh over the table-driven board contents
        for (int i = 0; i < 10; i++) mem1[vecs[i].idx] = vecs[i].code;
        pulse_start();
        watch(-1, -1, -1, bn, wn, un, cn, dn, bad);
        check("one_busy_cycles", bn, LEN);
        check("one_write_cycles", wn, WR);
        check("one_update_pulses", un, NC);
        check("one_ctr_clr_pulses", cn, 2);
        check("one_done_pulses", dn, 1);
        check("one_trace", bad, 0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("cell%0d_value", vecs[i].idx), cell_dv[vecs[i].idx], vecs[i].want);
            check($sformatf("cell%0d_writes", vecs[i].idx), cell_wr[vecs[i].idx], CP);
            check($sformatf("cell%0d_stable", vecs[i].idx), cell_chg[vecs[i].idx], 0);
        end

        // Start pulsed during BG queues exactly one more refresh
        fill_random();
        pulse_start();
        watch(501, 501, -1, bn, wn, un, cn, dn, bad);
        check("queued_busy_cycles", bn, 2 * LEN);
        check("queued_write_cycles", wn, 2 * WR);
        check("queued_update_pulses", un, 2 * NC);
        check("queued_ctr_clr_pulses", cn, 4);
        check("queued_done_pulses", dn, 2);
        check("queued_trace", bad, 0);
        repeat (40) @(negedge clk);
        check("queued_no_third", busy1, 0);

        // Start held through the first refresh: back-to-back, one FIN between
        fill_random();
        pulse_start();
        watch(0, LEN - 2, -1, bn, wn, un, cn, dn, bad);
        check("held_busy_cycles", bn, 2 * LEN);
        check("held_done_pulses", dn, 2);
        check("held_trace", bad, 0);
        repeat (40) @(negedge clk);
        check("held_no_third", busy1, 0);

        // Reset inside cell 20's draw window, with a refresh already queued
        fill_random();
        pulse_start();
        rst_t = CS + 20 * PER + 6;
        watch(300, 300, rst_t, bn, wn, un, cn, dn, bad);
        check("rst_mid_cycles", bn, rst_t + 1);
        check("rst_mid_trace", bad, 0);
        check("rst_mid_write", wr1, 0);
        check("rst_mid_busy", busy1, 0);
        check("rst_mid_vga", vga1, 0);
        check("rst_mid_draw_value", dv1, 0);
        check("rst_mid_mem_addr", addr1, 0);
        @(negedge clk);
        check("rst_mid_vga_later", vga1, 0);
        repeat (20) @(negedge clk);
        check("rst_mid_pending_cleared", busy1, 0);
        fill_random();
        pulse_start();
        watch(-1, -1, -1, bn, wn, un, cn, dn, bad);
        check("after_rst_busy_cycles", bn, LEN);
        check("after_rst_done_pulses", dn, 1);
        check("after_rst_trace", bad, 0);

        // Full-size build with three-cycle memory latency
        for (int i = 0; i < 64; i++) mem3[i] = 6'($urandom);
        mem3[5] = 6'b100100;
        mem3[7] = 6'b111000;
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        n = 0; w3 = 0; d3 = 0; c5 = 0; c5b = 0; c7 = 0; c7b = 0;
        while (busy3 === 1'b1 && n < LEN3 + 100) begin
            n++;
            w3 += int'(wr3);
            d3 += int'(done3);
            if (wr3 && addr3 == 6'd5) begin c5++; if (dv3 !== 6'b100100) c5b++; end
            if (wr3 && addr3 == 6'd7) begin c7++; if (dv3 !== 6'b000000) c7b++; end
            @(negedge clk);
        end
        check("lat3_busy_cycles", n, LEN3);
        check("lat3_write_cycles", w3, WR3);
        check("lat3_done_pulses", d3, 1);
        check("lat3_cell5_writes", c5, 256);
        check("lat3_cell5_value_errors", c5b, 0);
        check("lat3_cell7_writes", c7, 256);
        check("lat3_cell7_value_errors", c7b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_board_control.md
Name: draw_board_control

Overview:
- FSM that sequences the board-drawing datapath through one full screen refresh.
- Refresh order: white background clear, then all 64 cells in raster order (8x8 board, 16x16 pixels each), then the 16x16 turn-indicator square.
- Fetches each cell code from board memory and drives write, update_x_y and draw_value into the datapath.
- Sits between the game logic (raises start) and the datapath/VGA adapter.

Parameters:
- BG_PIXELS, 32768: write cycles spent on the background fill (long_counter span).
- CELL_PIXELS, 256: write cycles per cell and for the turn indicator (8-bit counter span).
- NUM_CELLS, 64: cells per refresh.
- MEM_LAT, 1: board-memory read latency in cycles (1..3).

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset.
- start  in  1  refresh request; level sampled every cycle.
- mem_addr  out  6  board memory read address, [5:3] = y, [2:0] = x.
- mem_rdata  in  6  cell code, [5] = owner, [4:0] = piece; valid MEM_LAT cycles after mem_addr.
- draw_value  out  6  code presented to the datapath.
- write  out  1  datapath write enable.
- update_x_y  out  1  one-cycle pulse; datapath increments x_y_pos.
- ctr_clr  out  1  one-cycle pulse; datapath zeroes counter, long_counter and x_y_pos.
- vga_plot  out  1  write delayed 1 cycle, aligned with the registered x/y/colour.
- busy  out  1  high from CLEAR through FIN inclusive.
- done  out  1  one-cycle pulse in FIN.

Behaviour:
- Clocking and reset: one clock, clk. resetn is synchronous and active-low. resetn low at any edge, including mid-refresh, has these effects:
  - state goes to IDLE;
  - all outputs go to 0 (draw_value = 0, mem_addr = 0);
  - the internal cell index, pixel counter, cell_q and pending flag are cleared.
- States: IDLE, CLEAR, BG, BGEND, FETCH, CELL, NEXT, TURN, FIN.
- IDLE: all strobes 0. start=1 moves to CLEAR next cycle.
- CLEAR (1 cycle): ctr_clr=1; cell index := 0; internal pixel counter := 0.
- BG (BG_PIXELS cycles): write=1, draw_value=6'b011000. Moves to BGEND when the internal counter reaches BG_PIXELS-1.
- BGEND (1 cycle): ctr_clr=1, write=0. Goes to FETCH.
- FETCH (MEM_LAT cycles): mem_addr = cell index, write=0. On the last cycle, cell_q := mem_rdata.
  - Sanitisation: if mem_rdata[4:0] is 5'b11000 or 5'b11100 (reserved screen codes), cell_q := 6'b000000 (empty) instead.
- CELL (CELL_PIXELS cycles): write=1, draw_value=cell_q, mem_addr held.
- NEXT (1 cycle): update_x_y=1, write=0, cell index += 1.
  - Index was NUM_CELLS-1: index wraps to 0 and the FSM goes to TURN.
  - Otherwise: FSM goes to FETCH.
- TURN (CELL_PIXELS cycles): write=1, draw_value=6'b011100.
- FIN (1 cycle): done=1.
  - pending set: go to CLEAR and clear pending.
  - pending clear: go to IDLE.
- Pending request: start=1 in any state other than IDLE sets pending. pending is never counted twice; at most one queued refresh.
- Pixel counter:
  - 15 bits, zeroed on every state entry.
  - The datapath's 8-bit counter wraps naturally after 256 writes, so no clear is issued between cells.
- Outputs: all registered except draw_value and mem_addr, which are decoded from state and registers.
- vga_plot: registered copy of write, reset 0.
- Default timing (MEM_LAT=1):
  - busy = 1 + 32768 + 1 + 64×(1+256+1) + 256 + 1 = 49539 cycles.
  - write-high cycles = 32768 + 64×256 + 256 = 49408.
  - update_x_y pulses = 64; ctr_clr pulses = 2.
- start held high continuously produces back-to-back refreshes with exactly 1 FIN cycle between them and no IDLE cycle.

Decomposition:
- Shared package draw_pkg holds:
  - code constants DRAW_BOARD=5'b11000, DRAW_TURN=5'b11100, DRAW_EMPTY=5'b00000, DRAW_WALL=5'b11111;
  - the state enum;
  - cell coordinate field widths.
- One natural sub-module: draw_step_counter. It is a loadable 15-bit counter with a terminal-count compare, reused for BG/CELL/TURN/FETCH lengths.

Test Plan:
1. Reset, then start pulse for 1 cycle, memory all 6'b000000 → busy high exactly 49539 cycles; done pulses once; 49408 write cycles; 64 update_x_y pulses; 2 ctr_clr pulses.
2. Memory cell 5'd9 (y=1, x=1) = 6'b100100, all others 0 → during the 10th CELL window, mem_addr=6'd9 and draw_value=6'b100100 for all 256 write cycles; the preceding FETCH shows mem_addr=9.
3. Memory cell 0 = 6'b011000, cell 1 = 6'b011100 → cell 0 and cell 1 each draw draw_value=6'b000000 for 256 cycles.
4. start pulsed again 1000 cycles into BG → done pulses, FIN is followed directly by CLEAR, second refresh completes, then IDLE; no third refresh.
5. resetn driven low for 1 cycle during cell 20's CELL window → next cycle state is IDLE, write=0, busy=0, vga_plot=0 one cycle later; a subsequent start gives the full 49539-cycle refresh.
6. MEM_LAT=3 build, start pulse → busy = 1 + 32768 + 1 + 64×260 + 256 + 1 = 49667 cycles; cell_q captures the value valid on the third FETCH cycle.
